prog_counter: RTL and testbench
===============================

Name:
prog_counter

Overview:
- Program counter register for the single-cycle CPU datapath.
- Holds the current instruction-fetch address `addr`, which drives the instruction memory.
- Each cycle it advances by one instruction, jumps to an absolute target, takes a PC-relative branch, or holds on stall.
- Sits between the control unit (jump/branch/stall decisions) and instruction memory.

Parameters:
- ADDR_W, 32, width of the PC and all address ports.
- RESET_ADDR, 0, value loaded into the PC by reset (must be a multiple of STEP).
- STEP, 4, increment in bytes per sequential instruction (power of two, at least 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 0 = stall/hold the PC.
- jump  input  1  load absolute target jump_addr.
- jump_addr  input  ADDR_W  absolute jump target.
- branch  input  1  take PC-relative branch.
- branch_off  input  ADDR_W  signed two's-complement byte offset, added to the current addr.
- addr  output  ADDR_W  current PC (registered).
- addr_plus  output  ADDR_W  addr + STEP (combinational; link/return address).
- misalign  output  1  sticky misaligned-target flag; present only with PC_MISALIGN_EN.

Behaviour:
- All state updates occur on the rising clk edge. addr is a flop output with no combinational path from any input.
- Next-value priority, evaluated each edge:
  - rst=1: addr <= RESET_ADDR.
  - else en=0: hold addr; jump and branch are ignored.
  - else jump=1: addr <= jump_addr. Jump wins when jump and branch are both 1.
  - else branch=1: addr <= addr + branch_off.
  - else: addr <= addr + STEP.
- Reset value: addr = RESET_ADDR; misalign = 0.
- Reset asserted mid-run takes effect at the next edge, regardless of en, jump or branch.
- While rst is held high, addr stays at RESET_ADDR.
- After rst falls, the first edge produces RESET_ADDR + STEP when en=1.
- Arithmetic is modulo 2^ADDR_W with no overflow flag.
  - Sequential wrap: addr = 2^ADDR_W - STEP goes to 0.
  - Negative branch_off wraps the same way.
- addr_plus = (addr + STEP) mod 2^ADDR_W, updated combinationally from addr.
- Latency: one cycle from a control input to the new addr.
- No internal state other than addr (and misalign when the feature is compiled in).

Optional Feature:
- Macro: PC_MISALIGN_EN.
- Defined:
  - The misalign port exists.
  - A jump or branch whose target has any of the low log2(STEP) bits set is rejected. The PC instead advances by STEP, as if neither jump nor branch were asserted.
  - The same edge sets misalign=1. It stays 1 until rst.
  - Aligned targets behave normally.
- Not defined:
  - No misalign port.
  - Targets are loaded unmodified, aligned or not.

Test Plan:
- Reset then run:
  - rst=1 for 3 edges → addr=0 each edge.
  - rst=0, en=1 → addr 4, 8, 12 on successive edges.
  - rst=1 again mid-run → addr=0 at the next edge.
- Stall: en=0 at addr=8, for 3 edges with jump=1, jump_addr=0x100 → addr stays 8. en=1 → addr=0x100.
- Jump vs branch priority: addr=0x20, jump=1, jump_addr=0x400, branch=1, branch_off=0x10 → addr=0x400.
- Branch back: addr=0x40, branch_off=0xFFFFFFF0 (-16) → addr=0x30; addr_plus=0x34.
- Wrap: force addr=0xFFFFFFFC via jump, then sequential → addr=0x00000000, addr_plus=4.
- With PC_MISALIGN_EN: addr=0x10, jump_addr=0x102 → addr=0x14, misalign=1, still 1 after further aligned jumps, cleared to 0 by rst.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: program counter register for the single-cycle CPU datapath.
// Holds the instruction-fetch address and advances it sequentially, loads an
// absolute jump target, adds a PC-relative branch offset, or holds on stall.
// Optional feature macro: PC_MISALIGN_EN -- rejects jump/branch targets that
// are not STEP-aligned (PC advances by STEP instead) and raises a sticky
// misalign flag that only reset clears.
module prog_counter #(
  parameter int ADDR_W     = 32,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_off,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_plus
`ifdef PC_MISALIGN_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [ADDR_W-1:0] RST_VAL  = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] STEP_VAL = ADDR_W'(STEP);
  // STEP is a power of two, so STEP-1 masks exactly the low log2(STEP) bits.
  // With STEP=1 the mask is zero and no target can ever be misaligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              redirect;
  logic [ADDR_W-1:0] next_addr;

  // Sequential and branch targets; both wrap modulo 2^ADDR_W by truncation.
  assign seq_addr   = addr + STEP_VAL;
  assign branch_tgt = addr + branch_off;
  assign addr_plus  = seq_addr;

  // Jump has priority over branch when both are requested.
  assign redirect     = jump | branch;
  assign redirect_tgt = jump ? jump_addr : branch_tgt;

`ifdef PC_MISALIGN_EN
  logic bad_tgt;

  // A redirect to a misaligned target is dropped in favour of the sequential
  // address; the same condition arms the sticky flag.
  assign bad_tgt = en & redirect & ((redirect_tgt & ALIGN_MASK) != '0);

  // Next-PC selection with misaligned redirects demoted to sequential fetch.
  always_comb begin
    next_addr = addr;
    if (en) begin
      if (redirect && !bad_tgt) next_addr = redirect_tgt;
      else                      next_addr = seq_addr;
    end
  end

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)          misalign <= 1'b0;
    else if (bad_tgt) misalign <= 1'b1;
  end
`else
  // Next-PC selection: stall holds, otherwise redirect target or sequential.
  always_comb begin
    next_addr = addr;
    if (en) begin
      if (redirect) next_addr = redirect_tgt;
      else          next_addr = seq_addr;
    end
  end
`endif

  // PC register; reset overrides stall and every redirect.
  always_ff @(posedge clk) begin
    if (rst) addr <= RST_VAL;
    else     addr <= next_addr;
  end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed scenarios plus randomized traffic checked against
// an arithmetic reference model of the program counter.
module tb_prog_counter;

  localparam int AW = 32;
  localparam longint unsigned MOD = 64'h1_0000_0000;
  localparam longint unsigned STP = 4;

  logic          clk = 1'b0;
  logic          rst, en, jump, branch;
  logic [AW-1:0] jump_addr, branch_off;
  logic [AW-1:0] addr, addr_plus;
`ifdef PC_MISALIGN_EN
  logic          misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned model_addr = 0;
  bit              model_mis  = 1'b0;

  always #5 clk = ~clk;

  prog_counter #(.ADDR_W(AW), .RESET_ADDR(0), .STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .branch     (branch),
    .branch_off (branch_off),
    .addr       (addr),
    .addr_plus  (addr_plus)
`ifdef PC_MISALIGN_EN
    ,
    .misalign   (misalign)
`endif
  );

  // Reference model: the PC as an integer advanced by the priority rules.
  task automatic model_step(input bit r, input bit e, input bit j,
                            input longint unsigned ja, input bit b,
                            input longint unsigned bo);
    longint unsigned tgt;
    if (r) begin
      model_addr = 0;
      model_mis  = 1'b0;
    end else if (e) begin
      if (j)      tgt = ja;
      else if (b) tgt = (model_addr + bo) % MOD;
      else        tgt = (model_addr + STP) % MOD;
`ifdef PC_MISALIGN_EN
      if ((j || b) && (tgt % STP) != 0) begin
        model_mis = 1'b1;
        tgt = (model_addr + STP) % MOD;
      end
`endif
      model_addr = tgt;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past edge.
  task automatic cycle(input bit r, input bit e, input bit j,
                       input logic [AW-1:0] ja, input bit b,
                       input logic [AW-1:0] bo);
    rst = r; en = e; jump = j; jump_addr = ja; branch = b; branch_off = bo;
    @(posedge clk);
    model_step(r, e, j, {32'h0, ja}, b, {32'h0, bo});
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, '0, 0, '0);
      n_checks++;
      if (addr !== 32'h0) begin
        n_fail++; $display("FAIL reset_hold: addr=%h expected=%h", addr, 32'h0);
      end
    end
    n_checks++;
    if (addr_plus !== 32'h4) begin
      n_fail++; $display("FAIL reset_addr_plus: addr_plus=%h expected=%h", addr_plus, 32'h4);
    end
`ifdef PC_MISALIGN_EN
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_misalign: misalign=%b expected=0", misalign);
    end
`endif
  endtask

  task automatic test_sequential;
    logic [AW-1:0] exp;
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 1, 0, '0, 0, '0);
      exp = 32'(4 * i);
      n_checks++;
      if (addr !== exp) begin
        n_fail++; $display("FAIL seq_step%0d: addr=%h expected=%h", i, addr, exp);
      end
    end
    // Mid-run reset wins over stall and jump.
    cycle(1, 0, 1, 32'h100, 1, 32'h10);
    n_checks++;
    if (addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: addr=%h expected=%h", addr, 32'h0);
    end
  endtask

  task automatic test_stall;
    cycle(0, 1, 0, '0, 0, '0);
    cycle(0, 1, 0, '0, 0, '0);
    n_checks++;
    if (addr !== 32'h8) begin
      n_fail++; $display("FAIL stall_setup: addr=%h expected=%h", addr, 32'h8);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 32'h100, 0, '0);
      n_checks++;
      if (addr !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold%0d: addr=%h expected=%h", i, addr, 32'h8);
      end
    end
    cycle(0, 1, 1, 32'h100, 0, '0);
    n_checks++;
    if (addr !== 32'h100) begin
      n_fail++; $display("FAIL stall_release: addr=%h expected=%h", addr, 32'h100);
    end
  endtask

  task automatic test_priority;
    cycle(0, 1, 1, 32'h20, 0, '0);
    cycle(0, 1, 1, 32'h400, 1, 32'h10);
    n_checks++;
    if (addr !== 32'h400) begin
      n_fail++; $display("FAIL jump_over_branch: addr=%h expected=%h", addr, 32'h400);
    end
  endtask

  task automatic test_branch_back;
    cycle(0, 1, 1, 32'h40, 0, '0);
    cycle(0, 1, 0, '0, 1, 32'hFFFF_FFF0);
    n_checks++;
    if (addr !== 32'h30) begin
      n_fail++; $display("FAIL branch_back: addr=%h expected=%h", addr, 32'h30);
    end
    n_checks++;
    if (addr_plus !== 32'h34) begin
      n_fail++; $display("FAIL branch_back_plus: addr_plus=%h expected=%h", addr_plus, 32'h34);
    end
    cycle(0, 1, 0, '0, 1, 32'h0000_0100);
    n_checks++;
    if (addr !== 32'h130) begin
      n_fail++; $display("FAIL branch_fwd: addr=%h expected=%h", addr, 32'h130);
    end
  endtask

  task automatic test_wrap;
    cycle(0, 1, 1, 32'hFFFF_FFFC, 0, '0);
    n_checks++;
    if (addr_plus !== 32'h0) begin
      n_fail++; $display("FAIL wrap_plus_top: addr_plus=%h expected=%h", addr_plus, 32'h0);
    end
    cycle(0, 1, 0, '0, 0, '0);
    n_checks++;
    if (addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_seq: addr=%h expected=%h", addr, 32'h0);
    end
    n_checks++;
    if (addr_plus !== 32'h4) begin
      n_fail++; $display("FAIL wrap_plus: addr_plus=%h expected=%h", addr_plus, 32'h4);
    end
    // Negative branch from 0 wraps downward.
    cycle(0, 1, 0, '0, 1, 32'hFFFF_FFF8);
    n_checks++;
    if (addr !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL wrap_branch: addr=%h expected=%h", addr, 32'hFFFF_FFF8);
    end
  endtask

`ifdef PC_MISALIGN_EN
  task automatic test_misalign;
    cycle(1, 1, 0, '0, 0, '0);
    cycle(0, 1, 1, 32'h10, 0, '0);
    cycle(0, 1, 1, 32'h102, 0, '0);
    n_checks++;
    if (addr !== 32'h14) begin
      n_fail++; $display("FAIL misalign_reject: addr=%h expected=%h", addr, 32'h14);
    end
    n_checks++;
    if (misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_set: misalign=%b expected=1", misalign);
    end
    cycle(0, 1, 1, 32'h200, 0, '0);
    n_checks++;
    if (addr !== 32'h200 || misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_sticky: addr=%h misalign=%b expected=%h/1", addr, misalign, 32'h200);
    end
    cycle(1, 1, 0, '0, 0, '0);
    n_checks++;
    if (misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear: misalign=%b expected=0", misalign);
    end
  endtask
`endif

  task automatic test_random;
    bit r, e, j, b;
    logic [AW-1:0] ja, bo;
    logic [AW-1:0] exp, expp;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      j  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 3) == 0);
      ja = $urandom;
      bo = $urandom;
      // Bias toward aligned targets so redirects are mostly taken.
      if ($urandom_range(0, 3) != 0) begin
        ja[1:0] = 2'b00;
        bo[1:0] = 2'b00;
      end
      cycle(r, e, j, ja, b, bo);
      exp  = model_addr[31:0];
      expp = 32'((model_addr + STP) % MOD);
      n_checks++;
      if (addr !== exp) begin
        n_fail++; $display("FAIL rand_addr[%0d]: addr=%h expected=%h", i, addr, exp);
      end
      n_checks++;
      if (addr_plus !== expp) begin
        n_fail++; $display("FAIL rand_plus[%0d]: addr_plus=%h expected=%h", i, addr_plus, expp);
      end
`ifdef PC_MISALIGN_EN
      n_checks++;
      if (misalign !== model_mis) begin
        n_fail++; $display("FAIL rand_misalign[%0d]: misalign=%b expected=%b", i, misalign, model_mis);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; jump = 1'b0; branch = 1'b0;
    jump_addr = '0; branch_off = '0;
    test_reset;
    test_sequential;
    test_stall;
    test_priority;
    test_branch_back;
    test_wrap;
`ifdef PC_MISALIGN_EN
    test_misalign;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
